deint_frame_ctrl: RTL and testbench

Frame sequencer for the receive-side deinterleaver. It accepts a frame request (rate code and symbol count) and latches the rate. It drives the deinterleaver's Start/Rate/x inputs for exactly NSym×Ncbps input bits plus one Ncbps flush block. It qualifies the deinterleaver's serial output with a correct per-frame valid window, because the deinterleaver's own Valid stays high once set. It sits between the demapper bit stream and the Viterbi depuncturer.

---
 rtl/deint_frame_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_deint_frame_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deint_frame_ctrl.sv
// deint_frame_ctrl
//
// Frame sequencer that sits in front of the receive-side deinterleaver.
// It accepts one frame request (rate code + OFDM symbol count), latches the
// rate, feeds NSym*Ncbps demapped bits into the deinterleaver and then one
// extra Ncbps block of zeros to flush the final symbol out. The deinterleaver's
// own valid flag stays high once set, so this block generates the per-frame
// output valid window, including a last-bit marker.
//
// Optional feature: define DEINT_CTRL_ABORT_EN to add the Abort input.
// Abort=1 in LOAD/RUN/FLUSH returns the FSM to IDLE on the next edge with
// no Done/Err pulse. Without the macro the port and its logic are absent.
//
// Handshake semantics:
//   Request side : a request is taken on a clock edge where ReqValid=1 and
//                  ReqReady=1 (ReqReady is high only in IDLE). A bad request
//                  is still consumed and answered with an Err pulse.
//   Input side   : InReady=1 only in RUN. In RUN the source must hold
//                  InValid=1 every cycle; a cycle with InValid=0 is an
//                  underflow and aborts the frame with ErrCode=11.
//   Output side  : no back-pressure. OutBit is meaningful when OutValid=1.
//
// Ports:
//   Clk, Reset        clock, synchronous active-high reset
//   ReqValid/ReqReady frame request handshake
//   ReqRate, ReqNSym  rate code and symbol count of the request
//   InBit/InValid     demapped coded bit stream, InReady = consumed this cycle
//   DiStart, DiRate,
//   DiX, DiY          deinterleaver control, data in and data out
//   OutBit, OutValid,
//   OutLast           qualified deinterleaved bit stream to the depuncturer
//   Busy              FSM not in IDLE
//   Done, Err         one-cycle completion / rejection pulses
//   ErrCode           01 bad rate, 10 NSym=0, 11 input underflow
//   DbgState          current FSM state encoding, for debug/checkers
//   Abort             (DEINT_CTRL_ABORT_EN only) frame abort

module deint_frame_ctrl #(
    parameter int NSYM_W = 12
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [3:0]        ReqRate,
    input  logic [NSYM_W-1:0] ReqNSym,
    input  logic              InBit,
    input  logic              InValid,
    output logic              InReady,
    output logic              DiStart,
    output logic [3:0]        DiRate,
    output logic              DiX,
    input  logic              DiY,
    output logic              OutBit,
    output logic              OutValid,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        ErrCode,
    output logic [2:0]        DbgState
`ifdef DEINT_CTRL_ABORT_EN
    ,
    input  logic              Abort
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [8:0]        bit_cnt, bit_cnt_nxt;
    logic [NSYM_W-1:0] sym_cnt, sym_cnt_nxt;
    logic [8:0]        ncbps_lat;
    logic [NSYM_W-1:0] nsym_lat;
    logic [3:0]        rate_lat;
    logic              err_q;
    logic [1:0]        err_code_q, err_code_nxt;
    logic              err_set;
    logic              accept;
    logic [8:0]        req_ncbps;
    logic              bit_last;
    logic              sym_last;

    // Coded bits per OFDM symbol for each rate code; 0 marks an invalid code.
    function automatic logic [8:0] rate_ncbps(input logic [3:0] r);
        case (r)
            4'b1101, 4'b1111: rate_ncbps = 9'd48;
            4'b0101, 4'b0111: rate_ncbps = 9'd96;
            4'b1001, 4'b1011: rate_ncbps = 9'd192;
            4'b0001, 4'b0011: rate_ncbps = 9'd288;
            default:          rate_ncbps = 9'd0;
        endcase
    endfunction

    assign req_ncbps = rate_ncbps(ReqRate);
    assign bit_last  = (bit_cnt == ncbps_lat - 9'd1);
    assign sym_last  = (sym_cnt == nsym_lat - NSYM_W'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            sym_cnt    <= '0;
            ncbps_lat  <= '0;
            nsym_lat   <= '0;
            rate_lat   <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sym_cnt    <= sym_cnt_nxt;
            err_q      <= err_set;
            err_code_q <= err_code_nxt;
            if (accept) begin
                ncbps_lat <= req_ncbps;
                nsym_lat  <= ReqNSym;
                rate_lat  <= ReqRate;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        sym_cnt_nxt  = sym_cnt;
        err_code_nxt = err_code_q;
        err_set      = 1'b0;
        accept       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ReqValid) begin
                    if (req_ncbps == 9'd0) begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'b01;
                    end else if (ReqNSym == '0) begin
                        err_set      = 1'b1;
                        err_code_nxt = 2'b10;
                    end else begin
                        accept       = 1'b1;
                        err_code_nxt = 2'b00;
                        bit_cnt_nxt  = '0;
                        sym_cnt_nxt  = '0;
                        state_nxt    = ST_LOAD;
                    end
                end
            end

            // One cycle with DiStart low so the deinterleaver restarts its
            // address counter under the newly latched rate.
            ST_LOAD: state_nxt = ST_RUN;

            ST_RUN: begin
                // Underflow is tested first so it also wins over the final bit.
                if (!InValid) begin
                    err_set      = 1'b1;
                    err_code_nxt = 2'b11;
                    state_nxt    = ST_IDLE;
                end else if (bit_last) begin
                    bit_cnt_nxt = '0;
                    if (sym_last) begin
                        state_nxt = ST_FLUSH;
                    end else begin
                        sym_cnt_nxt = sym_cnt + NSYM_W'(1);
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 9'd1;
                end
            end

            ST_FLUSH: begin
                if (bit_last) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_DONE;
                end else begin
                    bit_cnt_nxt = bit_cnt + 9'd1;
                end
            end

            ST_DONE: state_nxt = ST_IDLE;

            default: state_nxt = ST_IDLE;
        endcase

`ifdef DEINT_CTRL_ABORT_EN
        // A silent abort: no Err pulse and ErrCode untouched.
        if (Abort && (state == ST_LOAD || state == ST_RUN || state == ST_FLUSH)) begin
            state_nxt    = ST_IDLE;
            err_set      = 1'b0;
            err_code_nxt = err_code_q;
        end
`endif
    end

    assign ReqReady = (state == ST_IDLE);
    assign Busy     = (state != ST_IDLE);
    assign InReady  = (state == ST_RUN);
    assign DiStart  = (state == ST_RUN) || (state == ST_FLUSH);
    assign DiRate   = rate_lat;
    assign DiX      = (state == ST_RUN) & InBit;
    // The first RUN symbol only primes the deinterleaver, so output starts
    // with symbol 1 and the flush block carries the final symbol out.
    assign OutValid = ((state == ST_RUN) && (sym_cnt != '0)) || (state == ST_FLUSH);
    // Gated so the output reads 0 whenever no valid bit is presented.
    assign OutBit   = DiY & OutValid;
    assign OutLast  = (state == ST_FLUSH) && bit_last;
    assign Done     = (state == ST_DONE);
    assign Err      = err_q;
    assign ErrCode  = err_code_q;
    assign DbgState = state;

endmodule

// File: tb/tb_deint_frame_ctrl.sv
// Self-checking bench for deint_frame_ctrl. A behavioural 802.11a
// deinterleaver (ping-pong buffer, counter cleared while Start=0) closes the
// DiX -> DiY loop so the output stream can be compared against a reference
// deinterleave of the input bits built by the bench itself.

module tb_deint_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_rate;
  logic [11:0] req_nsym;
  logic        in_bit;
  logic        in_valid;
  logic        in_ready;
  logic        di_start;
  logic [3:0]  di_rate;
  logic        di_x;
  logic        di_y;
  logic        out_bit;
  logic        out_valid;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;
  logic        abort;

  int checks   = 0;
  int failures = 0;

  logic [0:0] exp_q[$];
  logic [0:0] ib[$];

  always #5 clk = ~clk;

  deint_frame_ctrl #(.NSYM_W(12)) dut (
    .Clk      (clk),
    .Reset    (reset),
    .ReqValid (req_valid),
    .ReqReady (req_ready),
    .ReqRate  (req_rate),
    .ReqNSym  (req_nsym),
    .InBit    (in_bit),
    .InValid  (in_valid),
    .InReady  (in_ready),
    .DiStart  (di_start),
    .DiRate   (di_rate),
    .DiX      (di_x),
    .DiY      (di_y),
    .OutBit   (out_bit),
    .OutValid (out_valid),
    .OutLast  (out_last),
    .Busy     (busy),
    .Done     (done),
    .Err      (err),
    .ErrCode  (err_code),
    .DbgState (dbg_state)
`ifdef DEINT_CTRL_ABORT_EN
    ,
    .Abort    (abort)
`endif
  );

  function automatic int ncbps_of(input logic [3:0] r);
    case (r)
      4'b1101, 4'b1111: return 48;
      4'b0101, 4'b0111: return 96;
      4'b1001, 4'b1011: return 192;
      4'b0001, 4'b0011: return 288;
      default:          return 0;
    endcase
  endfunction

  // Received index j -> deinterleaved index k (802.11a deinterleaver).
  function automatic int perm(input int j, input int n);
    int nbpsc, s, i;
    if (n == 0) return 0;
    nbpsc = n / 48;
    s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
    i = s * (j / s) + (j + (16 * j) / n) % s;
    return 16 * i - (n - 1) * ((16 * i) / n);
  endfunction

  function automatic logic pat(input int idx);
    int unsigned h;
    h = idx * 32'd2654435761;
    return h[13] ^ h[5];
  endfunction

  // ---- behavioural deinterleaver --------------------------------------
  logic mem [0:1][0:287];
  int   m_cnt = 0;
  logic m_bank = 1'b0;
  int   m_n;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 288; a++) mem[b][a] = 1'b0;
  end

  always_comb m_n = ncbps_of(di_rate);

  always @(posedge clk) begin
    if (!di_start) begin
      m_cnt  <= 0;
      m_bank <= 1'b0;
    end else begin
      mem[m_bank][perm(m_cnt, m_n)] <= di_x;
      if (m_cnt == m_n - 1) begin
        m_cnt  <= 0;
        m_bank <= ~m_bank;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign di_y = mem[~m_bank][m_cnt];

  // ---- check helper ----------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_di_start"},  di_start,  0);
    chk({tag, "_di_rate"},   di_rate,   0);
    chk({tag, "_di_x"},      di_x,      0);
    chk({tag, "_out_bit"},   out_bit,   0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_err"},       err,       0);
    chk({tag, "_err_code"},  err_code,  0);
  endtask

  // ---- driver tasks -----------------------------------------------------
  // Presents a request for one cycle; returns at the following negedge.
  task automatic issue_req(input logic [3:0] rate, input int nsym);
    @(negedge clk);
    req_valid = 1'b1;
    req_rate  = rate;
    req_nsym  = 12'(nsym);
    #1;
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic err_req(input logic [3:0] rate, input int nsym, input logic [1:0] code);
    issue_req(rate, nsym);
    #1;
    chk("bad_req_err",      err,      1);
    chk("bad_req_code",     err_code, code);
    chk("bad_req_busy",     busy,     0);
    chk("bad_req_ready",    req_ready, 1);
    @(negedge clk);
    #1;
    chk("bad_req_err_pulse", err,      0);
    chk("bad_req_code_hold", err_code, code);
    chk("bad_req_busy2",     busy,     0);
  endtask

  // Accepts a frame, checks the LOAD cycle and leaves the DUT entering RUN.
  task automatic start_frame(input logic [3:0] rate, input int nsym, input int n);
    int inv[288];
    issue_req(rate, nsym);
    #1;
    chk("load_busy",     busy,     1);
    chk("load_di_start", di_start, 0);
    chk("load_di_rate",  di_rate,  rate);
    chk("load_err_code", err_code, 0);
    req_rate = 4'b0000;
    exp_q.delete();
    ib.delete();
  endtask

  // Records a consumed input bit; after each full symbol pushes the
  // reference deinterleaved block onto the expected queue.
  task automatic record_in(input logic b, input int n, inout int in_cnt);
    int inv[288];
    int base;
    ib.push_back(b);
    in_cnt++;
    if (in_cnt % n == 0) begin
      for (int j = 0; j < n; j++) inv[perm(j, n)] = j;
      base = in_cnt - n;
      for (int k = 0; k < n; k++) exp_q.push_back(ib[base + inv[k]]);
    end
  endtask

  task automatic run_frame(input logic [3:0] rate, input int nsym, input int n);
    int t = 0, ds_cnt = 0, ov_cnt = 0, first_ov = -1, last_idx = -1;
    int done_t = -1, in_cnt = 0, bad_bits = 0, err_seen = 0, dix_bad = 0;
    bit started = 0;
    logic [0:0] e;
    start_frame(rate, nsym, n);
    for (int cyc = 0; cyc < (nsym + 1) * n + 20; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = pat(in_cnt);
      #1;
      if (di_start) started = 1;
      if (in_ready) begin
        if (di_x !== in_bit) dix_bad++;
        record_in(in_bit, n, in_cnt);
      end
      if (di_start) ds_cnt++;
      if (err) err_seen++;
      if (out_valid) begin
        if (first_ov < 0) first_ov = t;
        if (exp_q.size() == 0) bad_bits++;
        else begin
          e = exp_q.pop_front();
          if (out_bit !== e[0]) bad_bits++;
        end
        ov_cnt++;
        if (out_last) last_idx = ov_cnt;
      end
      if (done) begin
        done_t = t;
        break;
      end
      if (started) t++;
    end
    in_valid = 1'b0;
    chk("frame_di_start_cycles", ds_cnt,   (nsym + 1) * n);
    chk("frame_in_bits",         in_cnt,   nsym * n);
    chk("frame_out_valid_cnt",   ov_cnt,   nsym * n);
    chk("frame_first_out",       first_ov, n);
    chk("frame_out_last_idx",    last_idx, nsym * n);
    chk("frame_done_time",       done_t,   (nsym + 1) * n);
    chk("frame_out_bit_errors",  bad_bits, 0);
    chk("frame_di_x_errors",     dix_bad,  0);
    chk("frame_err_seen",        err_seen, 0);
    @(negedge clk);
    #1;
    chk("post_done_pulse", done,      0);
    chk("post_req_ready",  req_ready, 1);
    chk("post_busy",       busy,      0);
  endtask

  // Runs a frame and drops InValid on input bit number drop_at.
  task automatic underflow_frame(input logic [3:0] rate, input int nsym, input int n,
                                 input int drop_at);
    int in_cnt = 0, done_seen = 0;
    bit dropped = 0;
    start_frame(rate, nsym, n);
    for (int cyc = 0; cyc < (nsym + 1) * n + 20 && !dropped; cyc++) begin
      @(negedge clk);
      in_valid = (in_cnt == drop_at) ? 1'b0 : 1'b1;
      in_bit   = pat(in_cnt);
      #1;
      if (done) done_seen++;
      if (in_ready && in_valid) record_in(in_bit, n, in_cnt);
      else if (in_ready) dropped = 1;
    end
    chk("uf_dropped", dropped, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("uf_di_start", di_start,  0);
    chk("uf_err",      err,       1);
    chk("uf_err_code", err_code,  3);
    chk("uf_busy",     busy,      0);
    chk("uf_out_valid", out_valid, 0);
    chk("uf_done",     done + done_seen, 0);
    @(negedge clk);
    #1;
    chk("uf_err_pulse", err,  0);
    chk("uf_done2",     done, 0);
  endtask

  // Resets the DUT after a few FLUSH output bits of a one-symbol frame.
  task automatic reset_in_flush(input logic [3:0] rate, input int n);
    int in_cnt = 0, ov_cnt = 0;
    start_frame(rate, 1, n);
    for (int cyc = 0; cyc < 3 * n && ov_cnt < 5; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = pat(in_cnt);
      #1;
      if (in_ready) record_in(in_bit, n, in_cnt);
      if (out_valid) ov_cnt++;
    end
    chk("rst_reached_flush", ov_cnt, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_vals("rst_mid");
  endtask

`ifdef DEINT_CTRL_ABORT_EN
  task automatic abort_in_run(input logic [3:0] rate, input int nsym, input int n,
                              input int abort_at);
    int in_cnt = 0;
    bit hit = 0;
    start_frame(rate, nsym, n);
    for (int cyc = 0; cyc < 2 * n && !hit; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = pat(in_cnt);
      abort    = (in_cnt == abort_at) ? 1'b1 : 1'b0;
      #1;
      if (abort) hit = 1;
      if (in_ready) record_in(in_bit, n, in_cnt);
    end
    chk("abort_hit", hit, 1);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_busy",      busy,      0);
    chk("abort_di_start",  di_start,  0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_err",       err,       0);
    chk("abort_done",      done,      0);
    @(negedge clk);
    #1;
    chk("abort_err2",  err,  0);
    chk("abort_done2", done, 0);
  endtask
`endif

  // ---- vector table -----------------------------------------------------
  typedef struct {
    logic [3:0] rate;
    int         nsym;
    int         ncbps;
    logic       exp_err;
    logic [1:0] exp_code;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{4'b1101, 2, 48,  1'b0, 2'b00};
    vecs[1]  = '{4'b0011, 1, 288, 1'b0, 2'b00};
    vecs[2]  = '{4'b0000, 1, 0,   1'b1, 2'b01};
    vecs[3]  = '{4'b0101, 0, 96,  1'b1, 2'b10};
    vecs[4]  = '{4'b1111, 1, 48,  1'b0, 2'b00};
    vecs[5]  = '{4'b0101, 1, 96,  1'b0, 2'b00};
    vecs[6]  = '{4'b0111, 2, 96,  1'b0, 2'b00};
    vecs[7]  = '{4'b1001, 1, 192, 1'b0, 2'b00};
    vecs[8]  = '{4'b1110, 3, 0,   1'b1, 2'b01};
    vecs[9]  = '{4'b1011, 1, 192, 1'b0, 2'b00};
    vecs[10] = '{4'b0001, 1, 288, 1'b0, 2'b00};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_rate  = 4'b0000;
    req_nsym  = 12'd0;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals("por");

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].exp_err)
        err_req(vecs[i].rate, vecs[i].nsym, vecs[i].exp_code);
      else
        run_frame(vecs[i].rate, vecs[i].nsym, vecs[i].ncbps);
    end

    // Underflow at symbol 1 bit 50, then a new frame right after.
    underflow_frame(4'b1001, 3, 192, 192 + 50);
    run_frame(4'b1101, 1, 48);

    // Underflow on the very last input bit: error wins, no flush.
    underflow_frame(4'b1101, 1, 48, 47);

    // Reset during FLUSH, then a normal one-symbol frame.
    reset_in_flush(4'b0101, 96);
    run_frame(4'b0101, 1, 96);

`ifdef DEINT_CTRL_ABORT_EN
    abort_in_run(4'b1101, 2, 48, 10);
    run_frame(4'b1101, 1, 48);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
